// File: rtl/nf_mdu_if.sv
// nf_mdu_if: operand/handshake bundle between the execute stage and the
// iterative multiply/divide unit. The pipeline side is the master; the MDU
// is the slave.
interface nf_mdu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [2:0]      MDU_Code;
  logic            start;
  logic            kill;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output srcA, srcB, MDU_Code, start, kill,
    input  busy, valid, result
  );

  modport slave (
    input  srcA, srcB, MDU_Code, start, kill,
    output busy, valid, result
  );
endinterface

// File: rtl/nf_mdu.sv
// nf_mdu: iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes at launch, the core runs an unsigned
// shift-add multiply or restoring divide one bit per cycle, and a FIX cycle
// applies the sign and picks the output word. Divide-by-zero and signed
// overflow bypass the iterations.
// Optional macro NF_MDU_FAST_MUL_EN: multiplies use a one-cycle 64-bit
// combinational product instead of the shift-add loop.
module nf_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  nf_mdu_if.slave  mdu
);
  localparam int PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [PW-1:0]    p_q;         // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]  b_q;         // multiplier / divisor magnitude
  logic [XLEN-1:0]  spec_res_q;
  logic [XLEN-1:0]  result_q;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;       // operand signs differ: negate product/quotient
  logic             rneg_q;      // dividend negative: negate remainder
  logic             spec_q;
  logic             busy_q;
  logic             valid_q;

  logic             is_div, sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN-1:0]  mag_a, mag_b, spec_res;

  // Decode the incoming op: operand signedness, magnitudes, special cases.
  always_comb begin
    is_div   = mdu.MDU_Code[2];
    sgn_a    = ((mdu.MDU_Code == OP_MULH) || (mdu.MDU_Code == OP_MULHSU) ||
                (mdu.MDU_Code == OP_DIV)  || (mdu.MDU_Code == OP_REM)) &&
               mdu.srcA[XLEN-1];
    sgn_b    = ((mdu.MDU_Code == OP_MULH) || (mdu.MDU_Code == OP_DIV) ||
                (mdu.MDU_Code == OP_REM)) && mdu.srcB[XLEN-1];
    mag_a    = sgn_a ? (~mdu.srcA + 1'b1) : mdu.srcA;
    mag_b    = sgn_b ? (~mdu.srcB + 1'b1) : mdu.srcB;
    div_zero = is_div && (mdu.srcB == '0);
    div_ovf  = ((mdu.MDU_Code == OP_DIV) || (mdu.MDU_Code == OP_REM)) &&
               (mdu.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.srcB == '1);
    // code[1] separates REM/REMU from DIV/DIVU
    if (div_zero)
      spec_res = mdu.MDU_Code[1] ? mdu.srcA : '1;
    else
      spec_res = mdu.MDU_Code[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]    mul_sum, div_rem, div_trial;
  logic [PW-1:0]    p_step;

  // One iteration: shift-add multiply (LSB-first) or restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, p_q[PW-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_rem   = {p_q[PW-1:XLEN], p_q[XLEN-1]};
    div_trial = div_rem - {1'b0, b_q};
    if (code_q[2])
      p_step = div_trial[XLEN] ? {div_rem[XLEN-1:0],   p_q[XLEN-2:0], 1'b0}
                               : {div_trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    else
      p_step = {mul_sum, p_q[XLEN-1:1]};
  end

  logic [PW-1:0]    p_neg;
  logic [XLEN-1:0]  fix_res;

  // Sign correction and word select; the low half of the negated 64-bit
  // value doubles as the negated quotient.
  always_comb begin
    p_neg = neg_q ? (~p_q + 1'b1) : p_q;
    case (code_q)
      OP_MUL:                        fix_res = p_neg[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = p_neg[PW-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = p_neg[XLEN-1:0];
      default:                       fix_res = rneg_q ? (~p_q[PW-1:XLEN] + 1'b1)
                                                      : p_q[PW-1:XLEN];
    endcase
    if (spec_q)
      fix_res = spec_res_q;
  end

  // Control FSM with registered busy/valid/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      b_q        <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (mdu.kill) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (mdu.start) begin
            code_q     <= mdu.MDU_Code;
            b_q        <= mag_b;
            neg_q      <= sgn_a ^ sgn_b;
            rneg_q     <= sgn_a;
            spec_q     <= div_zero || div_ovf;
            spec_res_q <= spec_res;
            cnt_q      <= CNT_W'(XLEN - 1);
            p_q        <= {{XLEN{1'b0}}, mag_a};
            busy_q     <= 1'b1;
            if (div_zero || div_ovf)
              state_q <= S_FIX;
`ifdef NF_MDU_FAST_MUL_EN
            else if (!is_div) begin
              p_q     <= PW'(mag_a) * PW'(mag_b);
              state_q <= S_FIX;
            end
`endif
            else
              state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          p_q <= p_step;
          if (cnt_q == '0)
            state_q <= S_FIX;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mdu.busy   = busy_q;
  assign mdu.valid  = valid_q;
  assign mdu.result = result_q;

endmodule
